// File: rtl/alu_muldiv.sv
// Purpose : MIPS EX-stage unit: registered ALU with overflow flag, plus an iterative MULT/MULTU/DIV/DIVU engine driving HI/LO.
// Latency : ALU 1 cycle (out_valid pulse); muldiv WIDTH+2 cycles from start to md_done (2 cycles for divide-by-zero).
// Backpress: none on the ALU path; md_start is ignored while md_busy is high, and the caller must hold off.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   A, B, opCode, in_valid     ALU operands / operation select / request strobe
//   ALU_Out, zero, overflow    registered ALU result and flags, updated with out_valid
//   md_start, md_op            muldiv start strobe and op (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   md_busy, md_done           muldiv in progress / one-cycle completion pulse
//   div_by_zero                qualifies md_done: divide with B == 0, HI/LO left untouched
//   hi, lo                     HI/LO result registers
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       opCode,
    input  logic             in_valid,
    output logic [WIDTH-1:0] ALU_Out,
    output logic             zero,
    output logic             overflow,
    output logic             out_valid,
    input  logic             md_start,
    input  logic [1:0]       md_op,
    output logic             md_busy,
    output logic             md_done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH);

    // ------------------------------------------------------------------
    // ALU path
    // ------------------------------------------------------------------
    logic [SW-1:0]    w_shamt;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_ovf;

    logic [WIDTH-1:0] r_alu_out;
    logic             r_zero;
    logic             r_ovf;
    logic             r_out_vld;

    assign w_shamt = A[SW-1:0];
    assign w_sum   = A + B;
    assign w_diff  = A - B;

    always_comb begin
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
        case (opCode)
            4'b0000: w_alu_res = A & B;
            4'b0001: w_alu_res = A | B;
            4'b0010: begin
                w_alu_res = w_sum;
                // Same-sign operands producing an opposite-sign sum.
                w_alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
            end
            4'b0011: w_alu_res = A ^ B;
            4'b0100: w_alu_res = B << w_shamt;
            4'b0101: w_alu_res = B >> w_shamt;
            4'b0110: begin
                w_alu_res = w_diff;
                // Opposite-sign operands whose difference takes the subtrahend's sign.
                w_alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
            end
            4'b0111: w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            4'b1000: w_alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
            4'b1001: w_alu_res = $signed(B) >>> w_shamt;
            4'b1100: w_alu_res = ~(A | B);
            default: w_alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alu_out <= '0;
            r_zero    <= 1'b1;
            r_ovf     <= 1'b0;
            r_out_vld <= 1'b0;
        end else begin
            r_out_vld <= in_valid;
            if (in_valid) begin
                r_alu_out <= w_alu_res;
                r_zero    <= (w_alu_res == '0);
                r_ovf     <= w_alu_ovf;
            end
        end
    end

    assign ALU_Out   = r_alu_out;
    assign zero      = r_zero;
    assign overflow  = r_ovf;
    assign out_valid = r_out_vld;

    // ------------------------------------------------------------------
    // Multiply / divide engine
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } md_state_t;

    md_state_t r_state;
    md_state_t w_state_nxt;

    logic [WIDTH-1:0]   r_hacc;     // partial product high half / running remainder
    logic [WIDTH-1:0]   r_lacc;     // multiplier -> product low half / dividend -> quotient
    logic [WIDTH-1:0]   r_mcand;    // multiplicand or divisor magnitude
    logic [CW-1:0]      r_cnt;
    logic               r_op_div;
    logic               r_dbz_pend;
    logic               r_neg_lo;   // product / quotient needs negating
    logic               r_neg_hi;   // remainder needs negating (dividend sign)
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_md_done;
    logic               r_dbz;

    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_start_dbz;
    logic               w_accept;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shrem;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_rem;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_neg;

    // Signed ops run on magnitudes; the most-negative value maps to 2^(WIDTH-1),
    // which still fits unsigned, so MIN / -1 wraps back to MIN with no special case.
    assign w_signed    = ~md_op[0];
    assign w_a_neg     = w_signed & A[WIDTH-1];
    assign w_b_neg     = w_signed & B[WIDTH-1];
    assign w_a_mag     = w_a_neg ? -A : A;
    assign w_b_mag     = w_b_neg ? -B : B;
    assign w_start_dbz = md_op[1] & (B == '0);
    assign w_accept    = (r_state == S_IDLE) & md_start;

    // Shift-add step: add multiplicand when the multiplier LSB is set, then shift the pair right.
    assign w_mul_sum   = {1'b0, r_hacc} + (r_lacc[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});

    // Restoring step: remainder is always < divisor, so the shifted value is < 2*divisor
    // and a successful subtraction fits back into WIDTH bits.
    assign w_div_shrem = {r_hacc, r_lacc[WIDTH-1]};
    assign w_div_ge    = (w_div_shrem >= {1'b0, r_mcand});
    assign w_div_rem   = w_div_ge ? (w_div_shrem[WIDTH-1:0] - r_mcand) : w_div_shrem[WIDTH-1:0];

    assign w_prod      = {r_hacc, r_lacc};
    assign w_prod_neg  = -w_prod;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (md_start) w_state_nxt = w_start_dbz ? S_FIX : S_CALC;
            S_CALC: if (r_cnt == CW'(WIDTH-1)) w_state_nxt = S_FIX;
            S_FIX:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hacc     <= '0;
            r_lacc     <= '0;
            r_mcand    <= '0;
            r_cnt      <= '0;
            r_op_div   <= 1'b0;
            r_dbz_pend <= 1'b0;
            r_neg_lo   <= 1'b0;
            r_neg_hi   <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_md_done  <= 1'b0;
            r_dbz      <= 1'b0;
        end else begin
            r_md_done <= 1'b0;
            r_dbz     <= 1'b0;
            if (w_accept) begin
                r_op_div   <= md_op[1];
                r_dbz_pend <= w_start_dbz;
                r_hacc     <= '0;
                r_lacc     <= w_a_mag;
                r_mcand    <= w_b_mag;
                r_cnt      <= '0;
                r_neg_lo   <= w_a_neg ^ w_b_neg;
                r_neg_hi   <= w_a_neg;
            end else if (r_state == S_CALC) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_op_div) begin
                    r_hacc <= w_div_rem;
                    r_lacc <= {r_lacc[WIDTH-2:0], w_div_ge};
                end else begin
                    r_hacc <= w_mul_sum[WIDTH:1];
                    r_lacc <= {w_mul_sum[0], r_lacc[WIDTH-1:1]};
                end
            end else if (r_state == S_FIX) begin
                r_md_done <= 1'b1;
                r_dbz     <= r_dbz_pend;
                if (!r_dbz_pend) begin
                    if (r_op_div) begin
                        r_lo <= r_neg_lo ? -r_lacc : r_lacc;
                        r_hi <= r_neg_hi ? -r_hacc : r_hacc;
                    end else begin
                        {r_hi, r_lo} <= r_neg_lo ? w_prod_neg : w_prod;
                    end
                end
            end
        end
    end

    assign md_busy     = (r_state != S_IDLE);
    assign md_done     = r_md_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule
